// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared encodings for the I2C slave and its register bank
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_READ_WAIT,
    ST_RESP
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int CTRL_RW = 1;
  localparam int LB_ACK  = 0;
  localparam int LB_DONE = 1;

  localparam logic [7:0] NACK_READ_DATA = 8'hFF;

endpackage

// File: rtl/reg_bank_mem.sv
// rtl/reg_bank_mem.sv - DEPTH x DATA_W register array, synchronous write, registered read
module reg_bank_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // clear is driven by the parent's reset so the whole array returns to zero
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/i2c_register_bank.sv
// rtl/i2c_register_bank.sv - register file behind the I2C slave; optional REG_WRITE_PROTECT_EN
module i2c_register_bank
  import i2c_pkg::*;
#(
  parameter int              ADDR_W       = 7,
  parameter int              DATA_W       = 8,
  parameter int              DEPTH        = 128,
  parameter logic [ADDR_W-1:0] PROTECT_BASE = 7'h70
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [1:0]        control_signals,
  input  logic [7:0]        address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        control_last_block,
  output logic              busy,
  output logic              drop_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef REG_WRITE_PROTECT_EN
  localparam bit PROTECT_ON = 1'b1;
`else
  localparam bit PROTECT_ON = 1'b0;
`endif

  state_t              state;
  state_t              state_nx;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                ack_q;
  logic                in_range;
  logic                protected_hit;
  logic                writable;
  logic                mem_wr;
  logic                mem_rd;
  logic [DATA_W-1:0]   rd_data;
  logic                unused_inputs;

  assign unused_inputs = ^{control_signals[0], address[7:ADDR_W]};

  assign in_range      = 32'(addr_q) < DEPTH;
  assign protected_hit = PROTECT_ON && (addr_q >= PROTECT_BASE);
  assign writable      = in_range && !protected_hit;
  assign mem_wr        = (state == ST_WRITE) && writable;
  assign mem_rd        = (state == ST_READ);

  reg_bank_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk     (clk),
    .clear   (reset),
    .wr_en   (mem_wr),
    .wr_addr (addr_q[IDX_W-1:0]),
    .wr_data (data_q),
    .rd_en   (mem_rd),
    .rd_addr (addr_q[IDX_W-1:0]),
    .rd_data (rd_data)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (req) begin
          state_nx = (control_signals[CTRL_RW] == RW_READ) ? ST_READ : ST_WRITE;
        end
      end
      ST_WRITE:     state_nx = ST_RESP;
      ST_READ:      state_nx = ST_READ_WAIT;
      ST_READ_WAIT: state_nx = ST_RESP;
      ST_RESP:      state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      ack_q    <= 1'b0;
      data_out <= '0;
      drop_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && req) begin
        addr_q <= address[ADDR_W-1:0];
        data_q <= data_in;
      end
      if (state != ST_IDLE && req) begin
        drop_err <= 1'b1;
      end
      if (state == ST_WRITE) begin
        ack_q <= writable;
      end
      // out-of-range reads alias into the array, so substitute the NACK pattern
      if (state == ST_READ_WAIT) begin
        ack_q    <= in_range;
        data_out <= in_range ? rd_data : DATA_W'(NACK_READ_DATA);
      end
    end
  end

  assign busy                        = (state == ST_WRITE) || (state == ST_READ) ||
                                       (state == ST_READ_WAIT);
  assign control_last_block[LB_ACK]  = ack_q;
  assign control_last_block[LB_DONE] = (state == ST_RESP);

endmodule

// File: tb/tb_i2c_register_bank.sv
// tb/tb_i2c_register_bank.sv - scoreboard bench for i2c_register_bank (DEPTH=64)
module tb_i2c_register_bank;

  localparam int         DEPTH = 64;
  localparam logic [6:0] PB    = 7'h30;
`ifdef REG_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic [1:0] control_signals;
  logic [7:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [1:0] control_last_block;
  logic       busy;
  logic       drop_err;

  i2c_register_bank #(
    .ADDR_W       (7),
    .DATA_W       (8),
    .DEPTH        (DEPTH),
    .PROTECT_BASE (PB)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .req                (req),
    .control_signals    (control_signals),
    .address            (address),
    .data_in            (data_in),
    .data_out           (data_out),
    .control_last_block (control_last_block),
    .busy               (busy),
    .drop_err           (drop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_rd;
    bit         ack;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model [128];
  logic [7:0] last_rd;
  bit         exp_drop;
  int         cyc;
  int         checks;
  int         errors;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic bit wr_ok(int a);
    return (a < DEPTH) && !(PROT && a >= int'(PB));
  endfunction

  // monitor: every done pulse must match the oldest outstanding request
  always begin
    @(posedge clk);
    #2;
    if (!reset && control_last_block[1] === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("ack", control_last_block[0], e.ack);
        chk(e.is_rd ? "read_data" : "data_hold", data_out, e.data);
        chk("busy_at_done", busy, 0);
        chk("drop_err", drop_err, exp_drop);
      end
    end
  end

  task automatic issue(bit rd, logic [7:0] adr, logic [7:0] d);
    exp_t e;
    int a;
    a = int'(adr[6:0]);
    req = 1'b1;
    control_signals = {rd, 1'($urandom)};
    address = adr;
    data_in = d;
    e.is_rd = rd;
    e.cyc = cyc + (rd ? 3 : 2);
    if (rd) begin
      e.ack  = (a < DEPTH);
      e.data = e.ack ? model[a] : 8'hFF;
      last_rd = e.data;
    end else begin
      e.ack = wr_ok(a);
      if (e.ack) model[a] = d;
      e.data = last_rd;
    end
    sb.push_back(e);
    @(negedge clk);
    req = 1'b0;
    chk("busy_after_req", busy, 1);
  endtask

  task automatic drop_pulse();
    req = 1'b1;
    control_signals = 2'($urandom);
    address = 8'($urandom);
    data_in = 8'($urandom);
    exp_drop = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
    last_rd = 8'h00;
    exp_drop = 1'b0;
  endtask

  initial begin
    cyc = 0;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    req = 1'b0;
    control_signals = 2'b00;
    address = 8'h00;
    data_in = 8'h00;
    clear_model();
    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_clb", control_last_block, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_drop_err", drop_err, 0);
    reset = 1'b0;
    @(negedge clk);

    issue(1'b1, 8'h05, 8'h00);
    wait_done();
    issue(1'b0, 8'h12, 8'hA5);
    wait_done();
    issue(1'b1, 8'h12, 8'h00);
    wait_done();
    issue(1'b0, 8'h50, 8'h77);
    wait_done();
    issue(1'b1, 8'h50, 8'h00);
    wait_done();
    issue(1'b0, 8'hBF, 8'h11);
    wait_done();
    issue(1'b1, 8'h3F, 8'h00);
    wait_done();

    issue(1'b0, {1'b0, PB + 7'd1}, 8'h3C);
    wait_done();
    issue(1'b1, {1'b0, PB + 7'd1}, 8'h00);
    wait_done();
    issue(1'b0, {1'b0, PB - 7'd1}, 8'h5A);
    wait_done();
    issue(1'b1, {1'b0, PB - 7'd1}, 8'h00);
    wait_done();

    issue(1'b0, 8'h20, 8'hC3);
    drop_pulse();
    chk("drop_err_set", drop_err, 1);
    wait_done();
    issue(1'b1, 8'h20, 8'h00);
    wait_done();

    issue(1'b1, 8'h12, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    clear_model();
    @(negedge clk);
    chk("midrst_data_out", data_out, 8'h00);
    chk("midrst_clb", control_last_block, 2'b00);
    chk("midrst_busy", busy, 0);
    chk("midrst_drop_err", drop_err, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    issue(1'b1, 8'h12, 8'h00);
    wait_done();

    for (int i = 0; i < 80; i++) begin
      bit rd;
      rd = 1'($urandom);
      issue(rd, 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 7) == 0) drop_pulse();
      wait_done();
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_register_bank.md
# i2c_register_bank

Register file that sits directly downstream of the I2C slave and consumes its address, data and read/write control outputs. Each request is a single-cycle strobe. The block performs one register write or read, then returns an acknowledge code and, for reads, the read data. Together with the slave it forms the addressable register space visible on the I2C bus.

## Interface
Parameters:
- ADDR_W, 7, register address width
- DATA_W, 8, register data width
- DEPTH, 128, number of implemented registers (≤ 2^ADDR_W)
- PROTECT_BASE, 7'h70, first write-protected address (used only with REG_WRITE_PROTECT_EN)

Ports:
- clk  in  1  single clock for the block
- reset  in  1  asynchronous, active-high reset
- req  in  1  request strobe; sampled only in IDLE
- control_signals  in  2  [1] = rw (1 read, 0 write); [0] reserved, ignored
- address  in  8  register address; [6:0] used, [7] ignored
- data_in  in  DATA_W  write data; sampled with req
- data_out  out  DATA_W  read data; valid from done onward until the next read completes
- control_last_block  out  2  [0] = ack (1 ACK, 0 NACK); [1] = done, a one-cycle pulse
- busy  out  1  high from the cycle after an accepted req until done
- drop_err  out  1  sticky flag; set when req arrives while busy

## Operation
- States are IDLE, WRITE, READ, READ_WAIT and RESP.
- IDLE:
  - On req=1, latch address[6:0], data_in and rw.
  - Go to WRITE if rw=0, otherwise READ.
  - Assert busy in the next cycle.
- WRITE:
  - If addr < DEPTH (and the address is not protected, see Configuration), commit data to mem[addr] and set ack=1.
  - Otherwise make no write and set ack=0.
  - Go to RESP.
- READ:
  - Issue a synchronous array read. Go to READ_WAIT.
- READ_WAIT:
  - Load data_out with mem[addr] and set ack=1.
  - If addr ≥ DEPTH, load data_out with 8'hFF and set ack=0.
  - Go to RESP.
- RESP:
  - Pulse done=1 for one cycle. Deassert busy in the same cycle.
  - Return to IDLE.
- The ack level holds until the next completion. The slave samples it at any time after done.
- A req in any state other than IDLE is dropped and sets drop_err. drop_err clears only on reset.
- Addresses do not auto-increment; incrementing is the slave's responsibility.

## Timing
- Latency is counted from the req cycle (cycle 0):
  - Write: memory updated at the edge ending cycle 1; done in cycle 2.
  - Read: data_out and ack valid from cycle 3; done in cycle 3.
- Back-to-back: a new req is accepted in the first IDLE cycle after RESP.
  - Peak throughput is one write per 3 cycles or one read per 4 cycles.
- Reset values:
  - mem all 0
  - data_out 0, control_last_block 2'b00
  - busy 0, drop_err 0
  - state IDLE
- Reset mid-operation: asserting reset at any point aborts immediately with no done pulse.
  - A write is committed only if the WRITE-state edge occurred before reset asserted.
- A req coincident with reset deassertion is ignored.

## Configuration
- REG_WRITE_PROTECT_EN:
  - Defined: writes to addresses PROTECT_BASE..DEPTH-1 are NACKed (ack=0) and memory is unchanged. Reads of those addresses behave normally.
  - Undefined: every address below DEPTH is writable, and PROTECT_BASE is unused.

## Structure
- Shared package i2c_pkg holds:
  - state enum
  - RW_READ=1 and RW_WRITE=0 constants
  - bit indices CTRL_RW=1, LB_ACK=0, LB_DONE=1
  - NACK_READ_DATA=8'hFF
- The slave imports the same rw and ack encodings from this package.
- Sub-module reg_bank_mem contains the DEPTH×DATA_W array with a synchronous write port and a registered read port. It has no reset of its own; the parent clears it on reset via an asynchronous reset of the array.

## Test plan
- Reset, then read addr 7'h05 → data_out=8'h00, ack=1, done in cycle 3.
- Write 8'hA5 to 7'h12, then read 7'h12 → write done in cycle 2 with ack=1; read returns 8'hA5.
- With DEPTH=64, write to 7'h50 → ack=0; a read of 7'h50 returns 8'hFF with ack=0.
- req pulsed while busy (one cycle after an accepted write) → second request dropped, drop_err=1, first write completes normally.
- With REG_WRITE_PROTECT_EN, write 8'h3C to 7'h71 → ack=0 and memory unchanged (read gives 8'h00); a write to 7'h6F → ack=1.
- Assert reset during READ_WAIT → no done pulse; all outputs return to reset values; a subsequent read works normally.
